// File: rtl/mem_arb_pkg.sv
// Shared types and lane constants for the data-memory port arbiter.
// Arbitration mode is selected in mem_port_arbiter by MEM_ARB_RR_EN.
package mem_arb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RD_WAIT   = 2'b01,
      RMW_WAIT  = 2'b10,
      RMW_WRITE = 2'b11
   } arb_state_t;

   // Encoding 11 is treated as a full word access.
   function automatic size_t norm_size(input logic [1:0] s);
      case (s)
         2'b00:   return BYTE;
         2'b01:   return HALF;
         default: return WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module mem_lane_unit
   import mem_arb_pkg::*;
(
   input  logic [1:0]        i_lane,
   input  size_t             i_size,
   input  logic              i_unsigned,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_ext,
   output logic [DATA_W-1:0] o_merge
);

   logic [4:0]        w_bofs;
   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;

   // Halfwords are naturally aligned, so only lane bit 1 selects them.
   assign w_bofs = {i_lane, 3'b000};
   assign w_byte = i_rdata[w_bofs +: BYTE_W];
   assign w_half = i_lane[1] ? i_rdata[DATA_W-1:HALF_W] : i_rdata[HALF_W-1:0];

   always_comb begin
      o_ext   = i_rdata;
      o_merge = i_rdata;
      case (i_size)
         BYTE: begin
            o_ext = {{(DATA_W-BYTE_W){~i_unsigned & w_byte[BYTE_W-1]}}, w_byte};
            o_merge[w_bofs +: BYTE_W] = i_wdata[BYTE_W-1:0];
         end
         HALF: begin
            o_ext = {{(DATA_W-HALF_W){~i_unsigned & w_half[HALF_W-1]}}, w_half};
            if (i_lane[1]) o_merge[DATA_W-1:HALF_W] = i_wdata[HALF_W-1:0];
            else           o_merge[HALF_W-1:0]      = i_wdata[HALF_W-1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the word-wide data memory with sub-word loads and RMW stores.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rq0_valid,
   output logic              rq0_ready,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic              rq0_we,
   input  logic [1:0]        rq0_size,
   input  logic              rq0_unsigned,
   input  logic [DATA_W-1:0] rq0_wdata,
   output logic              rq0_rvalid,
   output logic [DATA_W-1:0] rq0_rdata,
   input  logic              rq1_valid,
   output logic              rq1_ready,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic              rq1_we,
   input  logic [1:0]        rq1_size,
   input  logic              rq1_unsigned,
   input  logic [DATA_W-1:0] rq1_wdata,
   output logic              rq1_rvalid,
   output logic [DATA_W-1:0] rq1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        r_state;
   logic [ADDR_W-1:0] r_addr;
   size_t             r_size;
   logic              r_unsigned;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              r_gnt;
   logic [DATA_W-1:0] r_merge;

   logic              w_gnt;
   logic              w_idle;
   logic              w_go;
   logic [ADDR_W-1:0] w_addr;
   logic              w_we;
   size_t             w_size;
   logic              w_unsigned;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_ext;
   logic [DATA_W-1:0] w_merge;
   logic              w_rd;

`ifdef MEM_ARB_RR_EN
   logic r_last;
   // On conflict the port not granted last wins; reset value favours port 0.
   assign w_gnt = (rq0_valid & rq1_valid) ? ~r_last : ~rq0_valid;
`else
   assign w_gnt = ~rq0_valid;
`endif

   assign w_addr     = w_gnt ? rq1_addr     : rq0_addr;
   assign w_we       = w_gnt ? rq1_we       : rq0_we;
   assign w_size     = norm_size(w_gnt ? rq1_size : rq0_size);
   assign w_unsigned = w_gnt ? rq1_unsigned : rq0_unsigned;
   assign w_wdata    = w_gnt ? rq1_wdata    : rq0_wdata;

   assign w_idle    = (r_state == IDLE) & ~reset;
   assign rq0_ready = w_idle & rq0_valid & ~w_gnt;
   assign rq1_ready = w_idle & rq1_valid & w_gnt;
   assign w_go      = rq0_ready | rq1_ready;

   assign mem_addr  = (r_state == IDLE) ? {w_addr[ADDR_W-1:2], 2'b00}
                                        : {r_addr[ADDR_W-1:2], 2'b00};
   assign mem_we    = ~reset & ((w_go & w_we & (w_size == WORD)) |
                                ((r_state == RMW_WRITE) & r_we));
   assign mem_wdata = (r_state == RMW_WRITE) ? r_merge : w_wdata;

   assign w_rd       = (r_state == RD_WAIT) & ~reset;
   assign rq0_rvalid = w_rd & ~r_gnt;
   assign rq1_rvalid = w_rd & r_gnt;
   assign rq0_rdata  = w_ext;
   assign rq1_rdata  = w_ext;

   mem_lane_unit u_lane (
      .i_lane     (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_rdata    (mem_rdata),
      .i_wdata    (r_wdata),
      .o_ext      (w_ext),
      .o_merge    (w_merge)
   );

   // Request latch and transaction sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_size     <= BYTE;
         r_unsigned <= 1'b0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_gnt      <= 1'b0;
         r_merge    <= '0;
`ifdef MEM_ARB_RR_EN
         r_last     <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  r_addr     <= w_addr;
                  r_size     <= w_size;
                  r_unsigned <= w_unsigned;
                  r_wdata    <= w_wdata;
                  r_we       <= w_we;
                  r_gnt      <= w_gnt;
`ifdef MEM_ARB_RR_EN
                  r_last     <= w_gnt;
`endif
                  if (!w_we)               r_state <= RD_WAIT;
                  else if (w_size != WORD) r_state <= RMW_WAIT;
               end
            end
            RD_WAIT:   r_state <= IDLE;
            RMW_WAIT: begin
               r_merge <= w_merge;
               r_state <= RMW_WRITE;
            end
            RMW_WRITE: r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
   end

endmodule
